// File: rtl/lnk_chk_snk_pkg.sv
// Shared definitions for the link test sink: field widths, FSM encodings and
// the redundancy function also used by the matching test source.
package lnk_chk_snk_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 8;
  localparam int NS_REDUN_SIZE   = 8;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ACK   = 2'd2,
    ST_STALL = 2'd3
  } snk_state_t;

  // Full-width sum; callers truncate to their redundancy width (mod 2^RSZ).
  function automatic logic [31:0] calc_redun(input logic [31:0] src,
                                             input logic [31:0] dst,
                                             input logic [31:0] dat);
    return src + dst + dat;
  endfunction

endpackage

// File: rtl/lnk_chk_snk_if.sv
// Message channel of the two-phase req/ack test link.
// Handshake: a message is pending while req != ack; the master toggles req with
// all fields stable and holds them until the slave copies req onto ack.
interface lnk_chk_snk_if #(
  parameter int ASZ = 6,
  parameter int DSZ = 8,
  parameter int RSZ = 8
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/lnk_chk_snk_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) stepped every cycle; provides the
// random backpressure bits for the sink's optional stall state.
module lnk_lfsr16 (
  input  logic       i_clk,
  input  logic       reset,
  output logic [1:0] rnd
);
  logic [15:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign rnd = lfsr[1:0];
endmodule

// File: rtl/lnk_chk_snk.sv
// Test-link sink: checks data sequence, destination range and redundancy of each
// message, then acknowledges it. NS_SNK_RAND_STALL_EN adds random ack stalls.
module lnk_chk_snk
  import lnk_chk_snk_pkg::*;
#(
  parameter int ASZ      = NS_ADDRESS_SIZE,
  parameter int DSZ      = NS_DATA_SIZE,
  parameter int RSZ      = NS_REDUN_SIZE,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 55
) (
  input  logic           i_clk,
  input  logic           reset,
  lnk_chk_snk_if.slave   i0,
  output logic           err_0,
  output logic           err_1,
  output logic [DSZ-1:0] i0_ck_dat,
  output logic [DSZ-1:0] fst_err0_inp,
  output logic [DSZ-1:0] fst_err0_dat,
  output logic [15:0]    num_rcv,
  output snk_state_t     dbg_state
);

  snk_state_t     state;
  logic [ASZ-1:0] src_q;
  logic [ASZ-1:0] dst_q;
  logic [DSZ-1:0] dat_q;
  logic [RSZ-1:0] red_q;
  logic           req_q;
  logic           ack_q;
  logic [DSZ-1:0] exp_q;

  logic [RSZ-1:0] calc_red;
  logic           dat_bad;
  logic           adr_bad;

`ifdef NS_SNK_RAND_STALL_EN
  logic [1:0] stall_rnd;

  lnk_lfsr16 u_lfsr (
    .i_clk (i_clk),
    .reset (reset),
    .rnd   (stall_rnd)
  );
`endif

  // Signed compare keeps a zero MIN_ADDR meaningful without unsigned folding.
  always_comb begin
    calc_red = RSZ'(calc_redun(32'(src_q), 32'(dst_q), 32'(dat_q)));
    dat_bad  = (dat_q != exp_q) || (red_q != calc_red);
    adr_bad  = (int'(dst_q) < MIN_ADDR) || (int'(dst_q) > MAX_ADDR);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state        <= ST_WAIT;
      src_q        <= '0;
      dst_q        <= '0;
      dat_q        <= '0;
      red_q        <= '0;
      req_q        <= 1'b0;
      ack_q        <= 1'b0;
      exp_q        <= '0;
      err_0        <= 1'b0;
      err_1        <= 1'b0;
      i0_ck_dat    <= '0;
      fst_err0_inp <= '0;
      fst_err0_dat <= '0;
      num_rcv      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (i0.req != ack_q) begin
            src_q <= i0.src;
            dst_q <= i0.dst;
            dat_q <= i0.dat;
            red_q <= i0.red;
            req_q <= i0.req;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_0 <= err_0 | dat_bad;
          err_1 <= err_1 | adr_bad;
          if (!(err_0 || err_1) && (dat_bad || adr_bad)) begin
            fst_err0_inp <= dat_q;
            fst_err0_dat <= exp_q;
          end
          i0_ck_dat <= exp_q;
          // Resync to the received value so one corruption flags only once.
          exp_q     <= dat_q + DSZ'(1);
          if (num_rcv != 16'hFFFF) num_rcv <= num_rcv + 16'd1;
`ifdef NS_SNK_RAND_STALL_EN
          state <= ST_STALL;
`else
          state <= ST_ACK;
`endif
        end
`ifdef NS_SNK_RAND_STALL_EN
        ST_STALL: begin
          if (stall_rnd == 2'b00) state <= ST_ACK;
        end
`endif
        ST_ACK: begin
          ack_q <= req_q;
          state <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign i0.ack    = ack_q;
  assign dbg_state = state;

endmodule
